// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and a single-port memory.
// The memory read path has one cycle of latency from mem_addr to mem_in.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  req0;
   logic                  req1;
   logic                  we0;
   logic                  we1;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] wdata0;
   logic [DATA_WIDTH-1:0] wdata1;
   logic                  ack0;
   logic                  ack1;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  busy;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic [DATA_WIDTH-1:0] mem_in;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_in,
      input  ack0, ack1, rdata, busy, mem_we, mem_addr, mem_data
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_in,
      output ack0, ack1, rdata, busy, mem_we, mem_addr, mem_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two ports (0 = CPU, 1 = loader) one memory access
// at a time; request fields are latched at selection so the port may change them.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACCESS    = 2'd1,
      READ_DATA = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  prio_q, prio_d;
   logic                  owner_q, owner_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic                  any_req;
   logic                  win;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      any_req = bus.req0 | bus.req1;
      // A lone requester wins outright; on contention the pointer decides.
      win     = (bus.req0 & bus.req1) ? prio_q : bus.req1;

      state_d = state_q;
      prio_d  = prio_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = ACCESS;
               owner_d = win;
               prio_d  = ~win;
               we_d    = win ? bus.we1    : bus.we0;
               addr_d  = win ? bus.addr1  : bus.addr0;
               wdata_d = win ? bus.wdata1 : bus.wdata0;
            end
         end
         ACCESS:    state_d = we_q ? IDLE : READ_DATA;
         READ_DATA: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Acks are masked while rst is high so an aborted access never completes.
   always_comb begin
      bus.ack0     = 1'b0;
      bus.ack1     = 1'b0;
      bus.rdata    = '0;
      bus.busy     = (state_q != IDLE);
      bus.mem_we   = 1'b0;
      bus.mem_addr = '0;
      bus.mem_data = '0;

      unique case (state_q)
         ACCESS: begin
            bus.mem_we   = we_q;
            bus.mem_addr = addr_q;
            bus.mem_data = wdata_q;
            if (we_q && !rst) begin
               bus.ack0 = ~owner_q;
               bus.ack1 = owner_q;
            end
         end
         READ_DATA: begin
            bus.rdata = bus.mem_in;
            if (!rst) begin
               bus.ack0 = ~owner_q;
               bus.ack1 = owner_q;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   logic          ld_en   = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;
   logic [DW-1:0] mem [64];

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld_en)
         mem[ld_addr] <= ld_data;
      else if (bus.mem_we)
         mem[bus.mem_addr] <= bus.mem_data;
      bus.mem_in <= mem[bus.mem_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_ack0"},  {31'd0, bus.ack0},   32'd0);
      check_eq({tag, "_ack1"},  {31'd0, bus.ack1},   32'd0);
      check_eq({tag, "_busy"},  {31'd0, bus.busy},   32'd0);
      check_eq({tag, "_mwe"},   {31'd0, bus.mem_we}, 32'd0);
      check_eq({tag, "_maddr"}, {26'd0, bus.mem_addr}, 32'd0);
      check_eq({tag, "_mdata"}, {16'd0, bus.mem_data}, 32'd0);
      check_eq({tag, "_rdata"}, {16'd0, bus.rdata},  32'd0);
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   initial begin
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
      bus.mem_in = '0;

      @(negedge clk);
      load(6'd9, 16'hBEEF);
      load(6'd1, 16'h1111);
      load(6'd2, 16'h2222);
      load(6'd3, 16'h3333);
      load(6'd7, 16'h7777);
      check_quiet("reset");
      rst = 1'b0;

      // Port 0 write
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 6'd5; bus.wdata0 = 16'h1234;
      @(negedge clk);
      check_eq("wr_mwe",   {31'd0, bus.mem_we},   32'd1);
      check_eq("wr_maddr", {26'd0, bus.mem_addr}, 32'd5);
      check_eq("wr_mdata", {16'd0, bus.mem_data}, 32'h1234);
      check_eq("wr_ack0",  {31'd0, bus.ack0},     32'd1);
      check_eq("wr_ack1",  {31'd0, bus.ack1},     32'd0);
      bus.req0 = 0; bus.we0 = 0;
      @(negedge clk);
      check_quiet("wr_after");
      check_eq("wr_mem5", {16'd0, mem[5]}, 32'h1234);

      // Port 1 read
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 6'd9;
      @(negedge clk);
      check_eq("rd_maddr", {26'd0, bus.mem_addr}, 32'd9);
      check_eq("rd_mwe",   {31'd0, bus.mem_we},   32'd0);
      check_eq("rd_ack1a", {31'd0, bus.ack1},     32'd0);
      @(negedge clk);
      check_eq("rd_ack1",  {31'd0, bus.ack1},     32'd1);
      check_eq("rd_ack0",  {31'd0, bus.ack0},     32'd0);
      check_eq("rd_rdata", {16'd0, bus.rdata},    32'hBEEF);
      bus.req1 = 0;
      @(negedge clk);
      check_quiet("rd_after");

      // Continuous contention from reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.req0 = 1; bus.req1 = 1; bus.addr0 = 6'd1; bus.addr1 = 6'd2;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("rr_busy_acc", {31'd0, bus.busy}, 32'd1);
         check_eq("rr_maddr", {26'd0, bus.mem_addr}, (k % 2 == 1) ? 32'd2 : 32'd1);
         check_eq("rr_noack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
         @(negedge clk);
         check_eq("rr_ack", {30'd0, bus.ack1, bus.ack0}, (k % 2 == 1) ? 32'd2 : 32'd1);
         check_eq("rr_rdata", {16'd0, bus.rdata}, (k % 2 == 1) ? 32'h2222 : 32'h1111);
         if (k == 3) begin
            bus.req0 = 0; bus.req1 = 0;
         end
         @(negedge clk);
         check_eq("rr_busy_idle", {31'd0, bus.busy}, 32'd0);
      end

      // Address change while in flight
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 6'd3;
      @(negedge clk);
      check_eq("hold_maddr0", {26'd0, bus.mem_addr}, 32'd3);
      bus.addr0 = 6'd7;
      #1;
      check_eq("hold_maddr1", {26'd0, bus.mem_addr}, 32'd3);
      @(negedge clk);
      check_eq("hold_ack0",  {31'd0, bus.ack0},  32'd1);
      check_eq("hold_rdata", {16'd0, bus.rdata}, 32'h3333);
      bus.req0 = 0;
      @(negedge clk);

      // Reset during READ_DATA of a port 1 read
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 6'd9;
      @(negedge clk);
      check_eq("abort_acc_ack1", {31'd0, bus.ack1}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check_eq("abort_rd_ack1", {31'd0, bus.ack1}, 32'd0);
      @(negedge clk);
      check_eq("abort_rd_ack1n", {31'd0, bus.ack1}, 32'd0);
      check_eq("abort_rd_busy",  {31'd0, bus.busy}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b0; bus.req1 = 0;
      @(negedge clk);
      check_quiet("abort_after");
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 6'd10; bus.wdata0 = 16'hAAAA;
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 6'd11; bus.wdata1 = 16'hBBBB;
      @(negedge clk);
      check_eq("post_ack0",  {30'd0, bus.ack1, bus.ack0}, 32'd1);
      check_eq("post_maddr", {26'd0, bus.mem_addr}, 32'd10);
      bus.req0 = 0;
      @(negedge clk);
      @(negedge clk);
      check_eq("post_ack1",   {30'd0, bus.ack1, bus.ack0}, 32'd2);
      check_eq("post_maddr1", {26'd0, bus.mem_addr}, 32'd11);
      bus.req1 = 0;
      @(negedge clk);
      check_eq("post_mem10", {16'd0, mem[10]}, 32'hAAAA);
      check_eq("post_mem11", {16'd0, mem[11]}, 32'hBBBB);

      // Reset on the ACCESS edge of a port 0 write; prio must return to port 0
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 6'd12; bus.wdata0 = 16'h5A5A;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("rstw_ack0", {31'd0, bus.ack0},   32'd0);
      check_eq("rstw_mwe",  {31'd0, bus.mem_we}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b0; bus.req0 = 0; bus.we0 = 0;
      @(negedge clk);
      check_eq("rstw_busy",  {31'd0, bus.busy}, 32'd0);
      check_eq("rstw_mem12", {16'd0, mem[12]},  32'h5A5A);
      bus.req0 = 1; bus.addr0 = 6'd1;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 6'd2;
      @(negedge clk);
      check_eq("rstw_maddr", {26'd0, bus.mem_addr}, 32'd1);
      bus.req0 = 0; bus.req1 = 0;
      @(negedge clk);
      check_eq("rstw_ack",   {30'd0, bus.ack1, bus.ack0}, 32'd1);
      check_eq("rstw_rdata", {16'd0, bus.rdata}, 32'h1111);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6: memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: memory data width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1 each  access request, port 0 (CPU) / port 1 (loader); held high until matching ack.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read.
REQ-007 addr0, addr1  input  ADDR_WIDTH each  access address.
REQ-008 wdata0, wdata1  input  DATA_WIDTH each  write data.
REQ-009 ack0, ack1  output  1 each  one-cycle completion pulse per port.
REQ-010 rdata  output  DATA_WIDTH  read data; valid only in the ack cycle of a read.
REQ-011 busy  output  1  high while a transaction is in flight (state not IDLE).
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_addr  output  ADDR_WIDTH  memory address.
REQ-014 mem_data  output  DATA_WIDTH  memory write data.
REQ-015 mem_in  input  DATA_WIDTH  memory read data; valid the cycle after mem_addr is presented with mem_we=0.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, READ_DATA.
REQ-017 IDLE: no request -> stay. Any request -> select winner, latch its we/addr/wdata and owner ID into internal registers, go to ACCESS.
REQ-018 Arbitration SHALL be round-robin. Pointer prio names the preferred port. Only one port requesting -> that port wins regardless of prio. Both requesting -> port prio wins.
REQ-019 On each selection, prio SHALL become the non-selected port.
REQ-020 ACCESS: mem_addr, mem_we, mem_data SHALL be driven from the latched registers.
REQ-021 ACCESS with latched write: ack of the owner pulses this cycle, then go to IDLE.
REQ-022 ACCESS with latched read: no ack; go to READ_DATA.
REQ-023 READ_DATA: rdata = mem_in (combinational pass-through), ack of the owner pulses, then go to IDLE.
REQ-024 Outside ACCESS, mem_we, mem_addr and mem_data SHALL be 0.
REQ-025 Outside READ_DATA, rdata SHALL be 0.
REQ-026 Latency, counted from the IDLE cycle in which req is sampled high:
  - write: ack 1 cycle later;
  - read: ack 2 cycles later.
REQ-027 Requests SHALL be sampled only in IDLE. After a transaction there is at least one IDLE cycle before the next ACCESS.
REQ-028 Changes to req/we/addr/wdata after selection SHALL NOT affect the in-flight transaction, since latched values are used.
  - A req dropped before ack is a protocol violation; the transaction still completes and ack still pulses.
REQ-029 At most one of ack0/ack1 SHALL be high in any cycle. Never more than one memory transaction SHALL be in flight.
REQ-030 Both ports held requesting continuously SHALL alternate grants 0,1,0,1... with no port starved.

Reset
REQ-031 rst high at a clock edge SHALL force:
  - state = IDLE, prio = port 0, latched registers = 0;
  - all outputs 0 in the following cycle.
REQ-032 rst asserted mid-transaction (ACCESS or READ_DATA) SHALL abort it:
  - no ack issued for the aborted access;
  - a write whose ACCESS cycle coincides with the reset edge has already been presented to memory; a write not yet presented is not performed.
REQ-033 After rst deasserts, the first arbitration SHALL favour port 0 when both ports request.

Verification
REQ-034 Port 0 write addr=5, wdata=16'h1234 -> mem_we=1, mem_addr=5, mem_data=16'h1234 in cycle +1; ack0 in cycle +1; ack1 never asserted.
REQ-035 Port 1 read addr=9, memory holds 16'hBEEF -> mem_addr=9, mem_we=0 in cycle +1; ack1 and rdata=16'hBEEF in cycle +2.
REQ-036 Both ports request reads continuously from reset (addr0=1, addr1=2) -> ack order 0,1,0,1; each ack 2 cycles after its IDLE; busy low exactly one cycle between transactions.
REQ-037 Port 0 read in flight, addr0 changed to 7 during ACCESS -> mem_addr stays at the original address; ack0 returns the data at the original address.
REQ-038 rst pulsed during READ_DATA of a port 1 read -> no ack1; next cycle all outputs 0; a subsequent simultaneous req0/req1 grants port 0 first.
